hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Sequential hazard controller for the 5-stage MIPS pipeline.
- Tracks in-flight register writers in the E, M and W stages (destination, write enable, remaining Tnew).
- Compares them against the Tuse requirements of the instruction in D, and tracks the HI/LO multiply/divide unit (MDU) busy window.
- Produces the single D-stage stall and inserts E-stage bubbles. The top level wires this block between the D-stage decoder and the E/M/W pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu.
- CNT_W, 4, width of the MDU busy counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  reset; one clock, reset asynchronous and active-low.
- d_a1  in  5  rs index of D instruction.
- d_a2  in  5  rt index of D instruction.
- d_tuse_rs  in  2  Tuse of rs: 0, 1, 2; 3 = rs not read.
- d_tuse_rt  in  2  Tuse of rt, same encoding.
- d_a3  in  5  destination of D instruction.
- d_we  in  1  D instruction writes GPR.
- d_tnew  in  2  Tnew at E entry: 0 = link/lui-class, 1 = ALU, 2 = load.
- d_md_start  in  2  0 none, 1 mult-class, 2 div-class.
- d_md_use  in  1  D instruction reads/writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze PC and F/D register; bubble into E.
- e_a3, m_a3, w_a3  out  5 each  tracked destinations.
- e_we, m_we, w_we  out  1 each  tracked write enables.
- e_tnew, m_tnew  out  2 each  remaining Tnew.
- md_busy  out  1  MDU counter nonzero.

Behaviour:
- Reset (async, reset_n=0): all tracked a3/we/tnew = 0, MDU counter = 0. Effect: stall=0, md_busy=0. Reset mid-MDU-operation clears the counter immediately.
- Stage advance each rising edge:
  - W <= M.
  - M <= E with tnew = (e_tnew==0) ? 0 : e_tnew-1 (saturating, never wraps).
  - If stall=0: E <= D fields, i.e. we = d_we & (d_a3!=0), a3 = d_a3, tnew = d_tnew.
  - If stall=1: E <= bubble (a3=0, we=0, tnew=0).
- GPR stall (combinational, from current state and D inputs):
  - rs_hit_E = (d_tuse_rs!=3) & e_we & (d_a1==e_a3) & (d_a1!=0) & (e_tnew > d_tuse_rs).
  - rs_hit_M is the same with m_* fields.
  - rt_hit_E and rt_hit_M are the same with d_a2 / d_tuse_rt.
  - W-stage writers never stall; they are forwarded.
- MDU:
  - On an edge where stall=0 and d_md_start!=0, the counter loads MULT_CYCLES or DIV_CYCLES.
  - Otherwise the counter decrements if nonzero, independent of stall.
  - md_busy = (counter!=0).
  - md_stall = d_md_use & md_busy. The load happens on the same edge the starting instruction leaves D, so a back-to-back HI/LO user sees busy.
- stall = rs_hit_E | rs_hit_M | rt_hit_E | rt_hit_M | md_stall.
- Simultaneous events:
  - GPR hazard plus md start in D: stall wins; the counter does not load.
  - Counter reaching 0 on the same edge that a new start arrives: the load wins.
- Tnew = 3 never presented; treat as 2 (implementation clamps).

Decomposition:
- Shared package/header: TUSE_NONE=2'd3; MD_NONE/MD_MULT/MD_DIV encodings; Tnew constants T_ZERO/T_ALU/T_LOAD.
- One natural sub-module: mdu_busy_counter (load value, decrement, busy flag).
- Stall comparison stays inline.

Test Plan:
1. Load-use: lw $8 in E (e_tnew=2), D add with d_a1=8, tuse_rs=1 -> stall=1 one cycle. Next cycle m_tnew=1 > 1 false, so stall=0; E holds bubble (e_we=0).
2. Branch after ALU: addu $9 in E (tnew=1), D beq reading $9 (tuse_rs=0) -> stall 1 cycle. Then M tnew=0, so stall=0.
3. Register zero: E writes $0 with d_tnew=2, D reads $0 tuse 0 -> stall=0, e_we=0.
4. MDU: mult accepted, next instruction mflo (d_md_use=1) -> stall for exactly 5 cycles. md_busy deasserts in the cycle mflo proceeds. div repeats with 10 cycles.
5. Tuse none: lw $5 in E, D jal (tuse_rs=3, tuse_rt=3, a1=5) -> stall=0.
6. Async reset asserted mid-div with counter=6 -> md_busy=0 and all we=0 without waiting for a clock edge; after release, first instruction proceeds unstalled.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and small helpers for the D-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    // Tuse encoding: 0..2 is the stage distance at which the operand is
    // consumed; 3 marks an operand that is not read at all.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew at E entry.
    localparam logic [1:0] T_ZERO = 2'd0;  // link / lui class
    localparam logic [1:0] T_ALU  = 2'd1;  // ALU result
    localparam logic [1:0] T_LOAD = 2'd2;  // load data

    // Multiply/divide start request carried by the D instruction.
    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_op_e;

    // One tracked writer in the E or M stage.
    typedef struct packed {
        logic [4:0] a3;
        logic       we;
        logic [1:0] tnew;
    } stage_t;

    // Tnew of 3 is never produced by the decoder; fold it onto the load case.
    function automatic logic [1:0] clamp_tnew(input logic [1:0] t);
        return (t == 2'd3) ? T_LOAD : t;
    endfunction

    // Remaining Tnew one stage later, saturating at zero.
    function automatic logic [1:0] dec_tnew(input logic [1:0] t);
        return (t == T_ZERO) ? T_ZERO : t - 2'd1;
    endfunction

    // True when a source operand must wait for the writer held in stage s.
    function automatic logic reg_hit(input logic [4:0] src,
                                     input logic [1:0] tuse,
                                     input stage_t     s);
        return (tuse != TUSE_NONE) && s.we && (src == s.a3) &&
               (src != 5'd0) && (s.tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// Busy window of the HI/LO multiply/divide unit: loads a cycle count when an
// operation starts and counts down to zero.
module mdu_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt;

    // A new start always wins over the decrement, even when the count is
    // about to reach zero on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start_div) begin
            cnt <= DIV_LOAD;
        end else if (start_mult) begin
            cnt <= MULT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Busy whenever any cycles remain.
    always_comb begin
        busy = (cnt != '0);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks E/M/W register writers and the MDU busy
// window, and raises the single stall that freezes PC/F-D and bubbles E.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] d_a1,
    input  logic [4:0] d_a2,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic       d_we,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_start,
    input  logic       d_md_use,
    output logic       stall,
    output logic [4:0] e_a3,
    output logic [4:0] m_a3,
    output logic [4:0] w_a3,
    output logic       e_we,
    output logic       m_we,
    output logic       w_we,
    output logic [1:0] e_tnew,
    output logic [1:0] m_tnew,
    output logic       md_busy
);

    stage_t     e_q;
    stage_t     m_q;
    logic [4:0] w_a3_q;
    logic       w_we_q;

    logic gpr_stall;
    logic md_stall;
    logic start_mult;
    logic start_div;

    // Operand hazards against E and M only; W results are forwarded.
    always_comb begin
        gpr_stall = reg_hit(d_a1, d_tuse_rs, e_q) | reg_hit(d_a1, d_tuse_rs, m_q) |
                    reg_hit(d_a2, d_tuse_rt, e_q) | reg_hit(d_a2, d_tuse_rt, m_q);
        md_stall  = d_md_use & md_busy;
        stall     = gpr_stall | md_stall;
    end

    // An MDU operation only starts on the edge its instruction leaves D.
    always_comb begin
        start_mult = !stall && (d_md_start == MD_MULT);
        start_div  = !stall && (d_md_start == MD_DIV);
    end

    // Pipeline advance: E takes D (or a bubble on stall), M and W follow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_a3_q <= 5'd0;
            w_we_q <= 1'b0;
        end else begin
            w_a3_q <= m_q.a3;
            w_we_q <= m_q.we;
            m_q.a3   <= e_q.a3;
            m_q.we   <= e_q.we;
            m_q.tnew <= dec_tnew(e_q.tnew);
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.a3   <= d_a3;
                e_q.we   <= d_we && (d_a3 != 5'd0);
                e_q.tnew <= clamp_tnew(d_tnew);
            end
        end
    end

    // Expose the tracked state.
    always_comb begin
        e_a3   = e_q.a3;
        e_we   = e_q.we;
        e_tnew = e_q.tnew;
        m_a3   = m_q.a3;
        m_we   = m_q.we;
        m_tnew = m_q.tnew;
        w_a3   = w_a3_q;
        w_we   = w_we_q;
    end

    mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_mult (start_mult),
        .start_div  (start_div),
        .busy       (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic checked
// against an age-based model of the in-flight writers and the MDU window.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] d_a1, d_a2, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
    logic       d_we, d_md_use;
    logic       stall, e_we, m_we, w_we, md_busy;
    logic [4:0] e_a3, m_a3, w_a3;
    logic [1:0] e_tnew, m_tnew;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_a1       (d_a1),
        .d_a2       (d_a2),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_we       (d_we),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .e_a3       (e_a3),
        .m_a3       (m_a3),
        .w_a3       (w_a3),
        .e_we       (e_we),
        .m_we       (m_we),
        .w_we       (w_we),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .md_busy    (md_busy)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [1:0] tr, input logic [1:0] tt,
                         input logic [4:0] a3, input logic we, input logic [1:0] tn,
                         input logic [1:0] ms, input logic mu);
        d_a1 = a1; d_a2 = a2; d_tuse_rs = tr; d_tuse_rt = tt;
        d_a3 = a3; d_we = we; d_tnew = tn; d_md_start = ms; d_md_use = mu;
        #1;
    endtask

    task automatic drive_idle();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        tests++; if ({e_we, m_we, w_we} !== 3'b000) begin fails++; $display("FAIL reset_we: got %b want 000", {e_we, m_we, w_we}); end
        tests++; if ({e_a3, m_a3, w_a3} !== 15'd0) begin fails++; $display("FAIL reset_a3: got %h want 0", {e_a3, m_a3, w_a3}); end
        tests++; if ({e_tnew, m_tnew} !== 4'd0) begin fails++; $display("FAIL reset_tnew: got %h want 0", {e_tnew, m_tnew}); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2, 2'd0, 1'b0);  // lw $8
        tick();
        drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 1'b1, 2'd1, 2'd0, 1'b0); // add reads $8
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b want 1", stall); end
        tests++; if (e_tnew !== 2'd2) begin fails++; $display("FAIL load_use_e_tnew: got %0d want 2", e_tnew); end
        tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_use_release: got %b want 0", stall); end
        tests++; if (e_we !== 1'b0) begin fails++; $display("FAIL load_use_bubble: got %b want 0", e_we); end
        tests++; if (m_tnew !== 2'd1 || m_a3 !== 5'd8) begin fails++; $display("FAIL load_use_m: got tnew %0d a3 %0d want 1 8", m_tnew, m_a3); end
        tick();
        tests++; if (e_a3 !== 5'd10 || e_we !== 1'b1) begin fails++; $display("FAIL load_use_issue: got a3 %0d we %b want 10 1", e_a3, e_we); end
    endtask

    task automatic test_branch_alu();
        apply_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 1'b1, 2'd1, 2'd0, 1'b0);  // addu $9
        tick();
        drive(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0);  // beq $9
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL branch_stall: got %b want 1", stall); end
        tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL branch_release: got %b want 0", stall); end
        tests++; if (m_tnew !== 2'd0 || m_we !== 1'b1) begin fails++; $display("FAIL branch_m: got tnew %0d we %b want 0 1", m_tnew, m_we); end
    endtask

    task automatic test_reg_zero();
        apply_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd2, 2'd0, 1'b0);  // lw $0
        tick();
        tests++; if (e_we !== 1'b0) begin fails++; $display("FAIL zero_e_we: got %b want 0", e_we); end
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 1'b1, 2'd1, 2'd0, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %b want 0", stall); end
    endtask

    task automatic test_mdu();
        int n;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, (k == 0) ? 2'd1 : 2'd2, 1'b1);
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mdu_start_stall k=%0d: got %b want 0", k, stall); end
            tick();
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1, 2'd0, 1'b1);  // mflo $2
            tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL mdu_busy k=%0d: got %b want 1", k, md_busy); end
            n = 0;
            while (stall === 1'b1 && n < 20) begin
                n++;
                tick();
            end
            tests++; if (n != ((k == 0) ? 5 : 10)) begin fails++; $display("FAIL mdu_stall_len k=%0d: got %0d want %0d", k, n, (k == 0) ? 5 : 10); end
            tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL mdu_idle k=%0d: got %b want 0", k, md_busy); end
            tick();
            tests++; if (e_a3 !== 5'd2 || e_we !== 1'b1) begin fails++; $display("FAIL mdu_issue k=%0d: got a3 %0d we %b want 2 1", k, e_a3, e_we); end
        end
    endtask

    task automatic test_tuse_none();
        apply_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd2, 2'd0, 1'b0);  // lw $5
        tick();
        drive(5'd5, 5'd5, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0, 2'd0, 1'b0); // jal
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL tuse_none_stall: got %b want 0", stall); end
        tick();
        tests++; if (e_a3 !== 5'd31 || e_tnew !== 2'd0) begin fails++; $display("FAIL tuse_none_issue: got a3 %0d tnew %0d want 31 0", e_a3, e_tnew); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 2'd2, 1'b1);  // div
        tick();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 1'b1, 2'd1, 2'd0, 1'b0);  // writers of $3
        repeat (4) tick();
        tests++; if (md_busy !== 1'b1 || w_we !== 1'b1) begin fails++; $display("FAIL async_pre: got busy %b w_we %b want 1 1", md_busy, w_we); end
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 1'b1, 2'd1, 2'd0, 1'b1);  // mflo
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL async_pre_stall: got %b want 1", stall); end
        reset_n = 1'b0;
        #1;
        tests++; if (md_busy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL async_clear: got busy %b stall %b want 0 0", md_busy, stall); end
        tests++; if ({e_we, m_we, w_we} !== 3'b000) begin fails++; $display("FAIL async_we: got %b want 000", {e_we, m_we, w_we}); end
        #1;
        reset_n = 1'b1;
        drive(5'd3, 5'd0, 2'd1, 2'd3, 5'd4, 1'b1, 2'd1, 2'd0, 1'b1);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL async_first_stall: got %b want 0", stall); end
        tick();
        tests++; if (e_a3 !== 5'd4 || e_we !== 1'b1) begin fails++; $display("FAIL async_first_issue: got a3 %0d we %b want 4 1", e_a3, e_we); end
    endtask

    // ---------------- random traffic vs reference model ----------------
    typedef struct {
        logic [4:0] a3;
        logic       we;
        int         tnew;  // Tnew at the moment it entered E
    } ins_t;

    task automatic test_random();
        ins_t       pipe[3];  // index = stages past E (0=E, 1=M, 2=W)
        int         cyc;
        int         md_end;   // first cycle at which the MDU is idle again
        logic       exp_stall;
        logic       hit;
        int         rem;
        logic [4:0] ra1, ra2, ra3;
        logic [1:0] rtr, rtt, rtn, rms;
        logic       rwe, rmu;

        apply_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{5'd0, 1'b0, 0};
        cyc = 0;
        md_end = 0;

        for (int it = 0; it < 400; it++) begin
            ra1 = 5'($urandom_range(0, 3));
            ra2 = 5'($urandom_range(0, 3));
            ra3 = 5'($urandom_range(0, 3));
            rtr = 2'($urandom_range(0, 3));
            rtt = 2'($urandom_range(0, 3));
            rtn = 2'($urandom_range(0, 3));
            rwe = 1'($urandom_range(0, 1));
            rms = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
            rmu = ($urandom_range(0, 3) == 0);
            drive(ra1, ra2, rtr, rtt, ra3, rwe, rtn, rms, rmu);

            hit = 1'b0;
            for (int k = 0; k < 2; k++) begin
                rem = pipe[k].tnew - k;
                if (rem < 0) rem = 0;
                if (pipe[k].we && rtr != 2'd3 && ra1 != 0 && pipe[k].a3 == ra1 && rem > int'(rtr)) hit = 1'b1;
                if (pipe[k].we && rtt != 2'd3 && ra2 != 0 && pipe[k].a3 == ra2 && rem > int'(rtt)) hit = 1'b1;
            end
            exp_stall = hit || (rmu && cyc < md_end);

            tests++; if (stall !== exp_stall) begin fails++; $display("FAIL rnd_stall it=%0d: got %b want %b", it, stall, exp_stall); end
            tests++; if (md_busy !== (cyc < md_end)) begin fails++; $display("FAIL rnd_md_busy it=%0d: got %b want %b", it, md_busy, cyc < md_end); end
            tests++; if (e_a3 !== pipe[0].a3 || e_we !== pipe[0].we) begin fails++; $display("FAIL rnd_e it=%0d: got %0d/%b want %0d/%b", it, e_a3, e_we, pipe[0].a3, pipe[0].we); end
            tests++; if (e_tnew !== 2'(pipe[0].tnew)) begin fails++; $display("FAIL rnd_e_tnew it=%0d: got %0d want %0d", it, e_tnew, pipe[0].tnew); end
            tests++; if (m_a3 !== pipe[1].a3 || m_we !== pipe[1].we) begin fails++; $display("FAIL rnd_m it=%0d: got %0d/%b want %0d/%b", it, m_a3, m_we, pipe[1].a3, pipe[1].we); end
            rem = (pipe[1].tnew > 0) ? pipe[1].tnew - 1 : 0;
            tests++; if (m_tnew !== 2'(rem)) begin fails++; $display("FAIL rnd_m_tnew it=%0d: got %0d want %0d", it, m_tnew, rem); end
            tests++; if (w_a3 !== pipe[2].a3 || w_we !== pipe[2].we) begin fails++; $display("FAIL rnd_w it=%0d: got %0d/%b want %0d/%b", it, w_a3, w_we, pipe[2].a3, pipe[2].we); end

            tick();
            cyc++;
            if (!exp_stall && rms != 2'd0) md_end = cyc + ((rms == 2'd1) ? 5 : 10);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (exp_stall) pipe[0] = '{5'd0, 1'b0, 0};
            else pipe[0] = '{ra3, rwe && ra3 != 0, (rtn == 2'd3) ? 2 : int'(rtn)};
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n = 1'b0;
        drive_idle();
        test_reset();
        test_load_use();
        test_branch_alu();
        test_reg_zero();
        test_mdu();
        test_tuse_none();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
